scan_window_ctrl: RTL and testbench

- Parametrised successor of the PMT scan-flag generator. Manages NUM_CH independent scan windows, each opened by a start pulse and closed by an end pulse, a timeout or an abort.
- Adds per-window tail extension, timeout, completed-scan counters and aggregated status.
- Sits in the clk_i domain after the CDC stage; all inputs are already synchronous to clk_i.

---
 rtl/scan_window_pkg.sv | 21 ++
 rtl/scan_window_ctrl_ch.sv | 172 +++++++++++++++++
 rtl/scan_window_ctrl.sv | 63 ++++++
 tb/tb_scan_window_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_window_pkg.sv
// Shared types and helpers for the scan window controller.
package scan_window_pkg;

    // Per-channel window states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        TAIL = 2'd2
    } scan_state_t;

    // Width of the tail-extension down-counter (TAIL_CYC is limited to 0..255).
    localparam int TAIL_W = 8;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/scan_window_ctrl_ch.sv
// One scan window channel: state machine, timeout timer, tail counter and
// saturating completed-scan counter.
// The timeout timer and sticky timeout flag exist only when SCAN_TIMEOUT_EN
// is defined; otherwise SCAN is left only through end or abort.
//
// state | meaning
// IDLE  | window closed, waiting for a start pulse
// SCAN  | window open, timer running, waiting for end or timeout
// TAIL  | close requested, scan held high for TAIL_CYC more cycles
module scan_window_ch
    import scan_window_pkg::*;
#(
    parameter int TMO_W    = 32,
    parameter int CNT_W    = 16,
    parameter int TAIL_CYC = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_start,
    input  logic             i_end,
    input  logic             i_abort,
    input  logic             i_clr,
    input  logic [TMO_W-1:0] i_timeout_cyc,
    output logic             o_scan,
    output logic             o_scan_nxt,
    output logic             o_scan_start,
    output logic             o_scan_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_scan_cnt
);

    localparam logic [TAIL_W-1:0] TAIL_LD   = TAIL_W'(TAIL_CYC);
    localparam bit                TAIL_NONE = (TAIL_CYC == 0);

    scan_state_t       r_state;
    logic [TAIL_W-1:0] r_tail;
    logic              r_scan;
    logic              r_start;
    logic              r_done;
    logic [CNT_W-1:0]  r_cnt;

    logic w_tmo_hit;
    logic w_close;
    logic w_tail_end;
    logic w_complete;
    logic w_scan_nxt;

`ifdef SCAN_TIMEOUT_EN
    logic [TMO_W-1:0] r_timer;
    logic             r_tmo;

    // Threshold is compared live; an equality match means a lowered threshold never fires.
    assign w_tmo_hit = (r_state == SCAN) && (i_timeout_cyc != '0) && (r_timer == i_timeout_cyc);

    // Timer counts SCAN cycles, reading 1 on the first one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timer <= '0;
        end else if (i_abort) begin
            r_timer <= '0;
        end else begin
            case (r_state)
                IDLE:    r_timer <= i_start ? TMO_W'(1) : '0;
                SCAN:    r_timer <= w_close ? '0 : r_timer + TMO_W'(1);
                default: r_timer <= '0;
            endcase
        end
    end

    // Sticky timeout flag; clear has priority, abort leaves it alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo <= 1'b0;
        end else if (i_clr) begin
            r_tmo <= 1'b0;
        end else if (!i_abort && w_close && w_tmo_hit) begin
            r_tmo <= 1'b1;
        end
    end

    assign o_timeout = r_tmo;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^i_timeout_cyc;
    assign w_tmo_hit    = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    assign w_close    = (r_state == SCAN) && (i_end || w_tmo_hit);
    assign w_tail_end = (r_state == TAIL) && (r_tail == TAIL_W'(1));
    assign w_complete = !i_abort && ((w_close && TAIL_NONE) || w_tail_end);

    // Next-cycle scan value, also exported so the top can register the OR in step.
    always_comb begin
        w_scan_nxt = 1'b0;
        if (!i_abort) begin
            case (r_state)
                IDLE:    w_scan_nxt = i_start;
                SCAN:    w_scan_nxt = !(w_close && TAIL_NONE);
                TAIL:    w_scan_nxt = !w_tail_end;
                default: w_scan_nxt = 1'b0;
            endcase
        end
    end

    // Window state machine with registered scan and pulse outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_tail  <= '0;
            r_scan  <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_scan  <= w_scan_nxt;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            if (i_abort) begin
                r_state <= IDLE;
                r_tail  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_state <= SCAN;
                            r_start <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (w_close) begin
                            if (TAIL_NONE) begin
                                r_state <= IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= TAIL;
                                r_tail  <= TAIL_LD;
                            end
                        end
                    end
                    TAIL: begin
                        if (w_tail_end) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_tail  <= '0;
                        end else begin
                            r_tail <= r_tail - TAIL_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Completed-scan counter; clear beats a coincident completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_complete) begin
            r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_W));
        end
    end

    assign o_scan       = r_scan;
    assign o_scan_nxt   = w_scan_nxt;
    assign o_scan_start = r_start;
    assign o_scan_done  = r_done;
    assign o_scan_cnt   = r_cnt;

endmodule

// File: rtl/scan_window_ctrl.sv
// Multi-channel scan window controller: NUM_CH independent windows with tail
// extension, completed-scan counters and aggregated scan status.
// Define SCAN_TIMEOUT_EN to build the per-channel timeout timer and flag.
module scan_window_ctrl
    import scan_window_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int TMO_W    = 32,
    parameter int CNT_W    = 16,
    parameter int TAIL_CYC = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH-1:0]       end_i,
    input  logic                    abort_i,
    input  logic                    clr_i,
    input  logic [TMO_W-1:0]        timeout_cyc_i,
    output logic [NUM_CH-1:0]       scan_o,
    output logic                    any_scan_o,
    output logic [NUM_CH-1:0]       scan_start_o,
    output logic [NUM_CH-1:0]       scan_done_o,
    output logic [NUM_CH-1:0]       timeout_o,
    output logic [NUM_CH*CNT_W-1:0] scan_cnt_o
);

    logic [NUM_CH-1:0] w_scan_nxt;
    logic              r_any;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        scan_window_ch #(
            .TMO_W    (TMO_W),
            .CNT_W    (CNT_W),
            .TAIL_CYC (TAIL_CYC)
        ) u_ch (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .i_start       (start_i[k]),
            .i_end         (end_i[k]),
            .i_abort       (abort_i),
            .i_clr         (clr_i),
            .i_timeout_cyc (timeout_cyc_i),
            .o_scan        (scan_o[k]),
            .o_scan_nxt    (w_scan_nxt[k]),
            .o_scan_start  (scan_start_o[k]),
            .o_scan_done   (scan_done_o[k]),
            .o_timeout     (timeout_o[k]),
            .o_scan_cnt    (scan_cnt_o[k*CNT_W +: CNT_W])
        );
    end

    // Aggregate flag built from next-state scan bits so it lines up with scan_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_scan_nxt;
        end
    end

    assign any_scan_o = r_any;

endmodule

// File: tb/tb_scan_window_ctrl.sv
// Scoreboard bench for scan_window_ctrl. Expected pulses and per-cycle output
// snapshots come from a window-level model (open/close/done cycle arithmetic).
module tb_scan_window_ctrl;

    localparam int NUM_CH   = 4;
    localparam int TMO_W    = 32;
    localparam int CNT_W    = 4;
    localparam int TAIL_CYC = 8;
    localparam int CNT_MAX  = 15;
`ifdef SCAN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       start_v = '0;
    logic [NUM_CH-1:0]       end_v = '0;
    logic                    abort = 1'b0;
    logic                    clr = 1'b0;
    logic [TMO_W-1:0]        tmo_thr = '0;
    logic [NUM_CH-1:0]       scan_o;
    logic                    any_scan_o;
    logic [NUM_CH-1:0]       scan_start_o;
    logic [NUM_CH-1:0]       scan_done_o;
    logic [NUM_CH-1:0]       timeout_o;
    logic [NUM_CH*CNT_W-1:0] scan_cnt_o;

    scan_window_ctrl #(
        .NUM_CH   (NUM_CH),
        .TMO_W    (TMO_W),
        .CNT_W    (CNT_W),
        .TAIL_CYC (TAIL_CYC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start_v),
        .end_i         (end_v),
        .abort_i       (abort),
        .clr_i         (clr),
        .timeout_cyc_i (tmo_thr),
        .scan_o        (scan_o),
        .any_scan_o    (any_scan_o),
        .scan_start_o  (scan_start_o),
        .scan_done_o   (scan_done_o),
        .timeout_o     (timeout_o),
        .scan_cnt_o    (scan_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int                      cyc;
        logic [NUM_CH-1:0]       scan;
        logic [NUM_CH-1:0]       tmo;
        logic [NUM_CH*CNT_W-1:0] cnt;
    } snap_t;

    typedef struct {
        int ch;
        int cyc;
        int cnt;
        bit tmo;
    } ev_t;

    snap_t snap_q[$];
    ev_t   start_q[$];
    ev_t   done_q[$];

    // window-level model state
    bit m_busy[NUM_CH];
    bit m_closed[NUM_CH];
    int m_start[NUM_CH];
    int m_done[NUM_CH];
    int m_cnt[NUM_CH];
    bit m_tmo[NUM_CH];

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input int ch, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s ch%0d cyc %0d: got 0x%0h expected 0x%0h", nm, ch, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_busy[k] = 0; m_closed[k] = 0; m_start[k] = 0;
            m_done[k] = 0; m_cnt[k] = 0; m_tmo[k] = 0;
        end
        snap_q.delete();
        start_q.delete();
        done_q.delete();
    endtask

    // Inputs applied in cycle c; predicts what the DUT shows in cycle c+1.
    task automatic model(input int c);
        snap_t sn;
        bit    complete;
        bit    hit;
        int    timer;
        sn.cyc = c + 1;
        for (int k = 0; k < NUM_CH; k++) begin
            complete = 0;
            hit = 0;
            if (abort) begin
                m_busy[k] = 0;
                m_closed[k] = 0;
            end else if (!m_busy[k]) begin
                if (start_v[k]) begin
                    m_busy[k] = 1;
                    m_closed[k] = 0;
                    m_start[k] = c;
                    start_q.push_back('{k, c + 1, 0, 1'b0});
                end
            end else if (!m_closed[k]) begin
                timer = c - m_start[k];
                hit = TMO_EN && (tmo_thr != 0) && (timer == int'(tmo_thr));
                if (end_v[k] || hit) begin
                    m_closed[k] = 1;
                    m_done[k] = c + TAIL_CYC + 1;
                end
            end
            if (m_busy[k] && m_closed[k] && c == m_done[k] - 1) begin
                complete = 1;
                m_busy[k] = 0;
                m_closed[k] = 0;
            end
            if (clr) begin
                m_cnt[k] = 0;
                m_tmo[k] = 0;
            end else begin
                if (hit && !abort) m_tmo[k] = 1;
                if (complete && m_cnt[k] < CNT_MAX) m_cnt[k]++;
            end
            if (complete) done_q.push_back('{k, c + 1, m_cnt[k], m_tmo[k]});
            sn.scan[k] = m_busy[k];
            sn.tmo[k]  = m_tmo[k];
            sn.cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
        end
        snap_q.push_back(sn);
    endtask

    task automatic step(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] e,
                        input logic a, input logic cl);
        @(posedge clk);
        #1;
        start_v = s;
        end_v   = e;
        abort   = a;
        clr     = cl;
        model(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_scan"}, -1, scan_o, 0);
        chk({nm, "_any"}, -1, any_scan_o, 0);
        chk({nm, "_start"}, -1, scan_start_o, 0);
        chk({nm, "_done"}, -1, scan_done_o, 0);
        chk({nm, "_tmo"}, -1, timeout_o, 0);
        chk({nm, "_cnt"}, -1, scan_cnt_o, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents pulses or a new cycle.
    always @(negedge clk) begin
        int idx;
        if (!rst && mon_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (scan_start_o[k]) begin
                    idx = -1;
                    for (int i = 0; i < start_q.size(); i++)
                        if (idx < 0 && start_q[i].ch == k) idx = i;
                    if (idx < 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL start_unexpected ch%0d cyc %0d: pulse seen, none expected", k, cyc);
                    end else begin
                        chk("start_cycle", k, cyc, start_q[idx].cyc);
                        start_q.delete(idx);
                    end
                end
                if (scan_done_o[k]) begin
                    idx = -1;
                    for (int i = 0; i < done_q.size(); i++)
                        if (idx < 0 && done_q[i].ch == k) idx = i;
                    if (idx < 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL done_unexpected ch%0d cyc %0d: pulse seen, none expected", k, cyc);
                    end else begin
                        chk("done_cycle", k, cyc, done_q[idx].cyc);
                        chk("done_cnt", k, scan_cnt_o[k*CNT_W +: CNT_W], done_q[idx].cnt);
                        chk("done_tmo", k, timeout_o[k], done_q[idx].tmo);
                        done_q.delete(idx);
                    end
                end
            end
            while (snap_q.size() > 0 && snap_q[0].cyc < cyc) begin
                n_cmp++; n_err++;
                $display("FAIL snap_missed cyc %0d: snapshot for cycle %0d never compared", cyc, snap_q[0].cyc);
                void'(snap_q.pop_front());
            end
            if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
                chk("scan", -1, scan_o, snap_q[0].scan);
                chk("any_scan", -1, any_scan_o, |snap_q[0].scan);
                chk("timeout", -1, timeout_o, snap_q[0].tmo);
                chk("scan_cnt", -1, scan_cnt_o, snap_q[0].cnt);
                void'(snap_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] rs, re;
        int thr_tab[5] = '{0, 3, 7, 12, 40};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // basic window on channel 0
        idle(5);
        step(4'b0001, '0, 1'b0, 1'b0);
        idle(19);
        step('0, 4'b0001, 1'b0, 1'b0);
        idle(15);

        // timeout on channel 2, then clear
        tmo_thr = 100;
        step(4'b0100, '0, 1'b0, 1'b0);
        idle(120);
        step('0, 4'b0100, 1'b0, 1'b0);
        idle(12);
        step('0, '0, 1'b0, 1'b1);
        idle(3);

        // start+end together in IDLE, in SCAN, and start during TAIL
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        idle(4);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        idle(2);
        step(4'b0010, '0, 1'b0, 1'b0);
        idle(12);

        // abort with channels 0 and 3 open; start on channel 1 dropped
        tmo_thr = 0;
        step(4'b1001, '0, 1'b0, 1'b0);
        idle(5);
        step(4'b0010, '0, 1'b1, 1'b0);
        idle(5);

        // counter saturation on channel 0
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, '0, 1'b0, 1'b0);
            step('0, 4'b0001, 1'b0, 1'b0);
            idle(10);
        end

        // clear coinciding with a completion
        step(4'b0001, '0, 1'b0, 1'b0);
        step('0, 4'b0001, 1'b0, 1'b0);
        idle(7);
        step('0, '0, 1'b0, 1'b1);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) tmo_thr = thr_tab[$urandom_range(0, 4)];
            for (int k = 0; k < NUM_CH; k++) begin
                rs[k] = ($urandom_range(0, 7) == 0);
                re[k] = ($urandom_range(0, 5) == 0);
            end
            step(rs, re, ($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0));
        end
        idle(20);

        // reset asserted during TAIL
        tmo_thr = 0;
        step(4'b0001, '0, 1'b0, 1'b0);
        idle(3);
        step('0, 4'b0001, 1'b0, 1'b0);
        idle(3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        start_v = '0; end_v = '0; abort = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        chk_all_zero("rst_tail");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // small threshold; times out only when the feature is built in
        tmo_thr = 5;
        step(4'b0001, '0, 1'b0, 1'b0);
        idle(20);
        step('0, 4'b0001, 1'b0, 1'b0);
        idle(12);

        idle(20);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("left_snap", -1, snap_q.size(), 0);
        chk("left_start", -1, start_q.size(), 0);
        chk("left_done", -1, done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
